// File: rtl/rshift_pkg.sv
// Shared widths for the shift/round/saturate pipeline: extension width,
// rounding intermediate width and the saturation counter width.
package rshift_pkg;
  localparam int CNT_W = 16;

  function automatic int ext_w(input int wa);
    return wa + 1;
  endfunction

  // One extra bit over the larger of the shifted value and the output so the
  // rounding increment can never lose a carry.
  function automatic int rnd_w(input int wa, input int wz);
    return ((wa + 1 > wz) ? wa + 1 : wz) + 1;
  endfunction
endpackage

// File: rtl/rshift_round_sat_pipe_sat_clip.sv
// Combinational clip of a signed intermediate to width_z bits, signed or
// unsigned range; sat flags any clipping.
module sat_clip #(
  parameter int width_i = 18,
  parameter int width_z = 8,
  parameter int signd_a = 1
) (
  input  logic signed [width_i-1:0] din,
  output logic        [width_z-1:0] dout,
  output logic                      sat
);
  logic signed [width_i-1:0] hi, lo;

  always_comb begin
    hi = '0;
    lo = '0;
    hi[width_z-1:0] = '1;
    if (signd_a != 0) begin
      hi[width_z-1] = 1'b0;
      lo[width_i-1:width_z-1] = '1;
    end
    if (din > hi) begin
      dout = hi[width_z-1:0];
      sat  = 1'b1;
    end else if (din < lo) begin
      dout = lo[width_z-1:0];
      sat  = 1'b1;
    end else begin
      dout = din[width_z-1:0];
      sat  = 1'b0;
    end
  end
endmodule

// File: rtl/rshift_round_sat_pipe.sv
// Two-stage right shift with optional round-half-up and saturation, valid/ready
// on both sides, plus a sticky-at-max count of saturated output transfers.
module rshift_round_sat_pipe
  import rshift_pkg::*;
#(
  parameter int width_a = 16,
  parameter int signd_a = 1,
  parameter int width_s = 4,
  parameter int width_z = 8,
  parameter int rnd_en  = 1
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [width_a-1:0] a,
  input  logic [width_s-1:0] s,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [width_z-1:0] z,
  output logic               sat,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   sat_cnt
);
  localparam int EW = ext_w(width_a);
  localparam int IW = rnd_w(width_a, width_z);

  logic [2:1]             vld_pipe;
  logic                   live, s1_en, s2_en, in_fire, out_fire;
  logic signed [EW-1:0]   ext, shf, sh1;
  logic                   g, g1;
  logic signed [IW-1:0]   sum;
  logic [width_z-1:0]     zc;
  logic                   satc;

  // Not ready until one clean edge has passed after reset release.
  always_ff @(posedge clk or posedge arst)
    if (arst) live <= 1'b0;
    else      live <= 1'b1;

  assign s2_en    = !vld_pipe[2] || out_rdy;
  assign s1_en    = !vld_pipe[1] || s2_en;
  assign in_rdy   = live && s1_en;
  assign in_fire  = in_vld && in_rdy;
  assign out_vld  = vld_pipe[2];
  assign out_fire = out_vld && out_rdy;

  always_ff @(posedge clk or posedge arst)
    if (arst) vld_pipe <= '0;
    else begin
      if (s1_en) vld_pipe[1] <= in_fire;
      if (s2_en) vld_pipe[2] <= vld_pipe[1];
    end

  // S1: extend, shift, capture the last bit shifted out as the guard
  assign ext = $signed({(signd_a != 0) ? a[width_a-1] : 1'b0, a});
  assign shf = ext >>> s;

  always_comb begin
    g = 1'b0;
    for (int i = 0; i < EW; i++)
      if (int'(s) == i + 1) g = ext[i];
    if (int'(s) > EW) g = ext[EW-1];
  end

  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      sh1 <= '0;
      g1  <= 1'b0;
    end else if (in_fire) begin
      sh1 <= shf;
      g1  <= g;
    end

  // S2: round in a widened signed intermediate, then clip
  always_comb begin
    sum = IW'(sh1);
    if (rnd_en != 0) sum = sum + IW'(g1);
  end

  sat_clip #(.width_i(IW), .width_z(width_z), .signd_a(signd_a)) u_clip (
    .din (sum),
    .dout(zc),
    .sat (satc)
  );

  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      z   <= '0;
      sat <= 1'b0;
    end else if (s2_en && vld_pipe[1]) begin
      z   <= zc;
      sat <= satc;
    end

  always_ff @(posedge clk or posedge arst)
    if (arst)                                   sat_cnt <= '0;
    else if (clr_cnt)                           sat_cnt <= '0;
    else if (out_fire && sat && sat_cnt != '1)  sat_cnt <= sat_cnt + 1'b1;
endmodule

// File: tb/tb_rshift_round_sat_pipe.sv
// Bench for rshift_round_sat_pipe: rounding and truncating instances side by
// side, an arithmetic reference model with scoreboard, plus literal checks.
module tb_rshift_round_sat_pipe;
  logic        clk = 1'b0, arst = 1'b1, in_vld = 1'b0, out_rdy = 1'b1, clr_cnt = 1'b0;
  logic [15:0] a = '0;
  logic [3:0]  s = '0;
  logic        in_rdy, out_vld, sat, in_rdy_t, out_vld_t, sat_t;
  logic [7:0]  z, z_t;
  logic [15:0] sat_cnt, sat_cnt_t;

  int checks = 0, errors = 0;
  logic [8:0] q[$], qt[$];
  int  cnt_m = 0, cnt_t = 0, n_out = 0, idx = 0;
  bit  live_m = 1'b0, acc;
  logic [15:0] bp_a[4] = '{16'h0100, 16'h0034, 16'hFF00, 16'h1234};
  logic [3:0]  bp_s[4] = '{4'd2, 4'd3, 4'd4, 4'd8};
  logic [15:0] tp_a[6] = '{16'hC000, 16'h0100, 16'hFF7F, 16'h00FF, 16'hFF01, 16'h5555};
  logic [3:0]  tp_s[6] = '{4'd15, 4'd1, 4'd0, 4'd1, 4'd1, 4'd15};

  always #5 clk = ~clk;

  rshift_round_sat_pipe #(.width_a(16), .signd_a(1), .width_s(4), .width_z(8), .rnd_en(1)) dut (
    .clk(clk), .arst(arst), .in_vld(in_vld), .in_rdy(in_rdy), .a(a), .s(s),
    .out_vld(out_vld), .out_rdy(out_rdy), .z(z), .sat(sat), .clr_cnt(clr_cnt), .sat_cnt(sat_cnt));

  rshift_round_sat_pipe #(.width_a(16), .signd_a(1), .width_s(4), .width_z(8), .rnd_en(0)) dut_t (
    .clk(clk), .arst(arst), .in_vld(in_vld), .in_rdy(in_rdy_t), .a(a), .s(s),
    .out_vld(out_vld_t), .out_rdy(out_rdy), .z(z_t), .sat(sat_t), .clr_cnt(clr_cnt), .sat_cnt(sat_cnt_t));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint fdiv(input longint n, input longint d);
    longint qq;
    qq = n / d;
    if ((n % d != 0) && (n < 0)) qq = qq - 1;
    return qq;
  endfunction

  // Result = floor(a/2^s + 1/2) when rounding, floor(a/2^s) otherwise, clipped to int8.
  function automatic logic [8:0] model(input logic [15:0] av, input logic [3:0] sv, input bit rnd);
    longint v, p, r;
    v = longint'($signed(av));
    p = longint'(1) << sv;
    r = rnd ? fdiv(2 * v + p, 2 * p) : fdiv(v, p);
    if (r > 127)  return {1'b1, 8'h7F};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(r)};
  endfunction

  always @(posedge clk or posedge arst) live_m <= !arst;

  always @(negedge clk) begin
    if (arst) begin
      q.delete(); qt.delete(); cnt_m = 0; cnt_t = 0;
      chk("rst_out_vld", out_vld, 0);
      chk("rst_out_vld_t", out_vld_t, 0);
      chk("rst_in_rdy", in_rdy, 0);
    end else begin
      chk("sat_cnt", sat_cnt, cnt_m);
      chk("sat_cnt_t", sat_cnt_t, cnt_t);
      chk("in_rdy", in_rdy, live_m && (q.size() < 2 || out_rdy));
      chk("in_rdy_t", in_rdy_t, live_m && (qt.size() < 2 || out_rdy));
      if (clr_cnt) cnt_m = 0;
      if (clr_cnt) cnt_t = 0;
      if (out_vld) begin
        if (q.size() == 0) chk("out_vld_spurious", out_vld, 0);
        else begin
          chk("result", {sat, z}, q[0]);
          if (out_rdy) begin
            if (q[0][8] && !clr_cnt && cnt_m < 65535) cnt_m++;
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (out_vld_t) begin
        if (qt.size() == 0) chk("out_vld_t_spurious", out_vld_t, 0);
        else begin
          chk("result_t", {sat_t, z_t}, qt[0]);
          if (out_rdy) begin
            if (qt[0][8] && !clr_cnt && cnt_t < 65535) cnt_t++;
            void'(qt.pop_front());
          end
        end
      end
      if (in_vld && in_rdy)   q.push_back(model(a, s, 1'b1));
      if (in_vld && in_rdy_t) qt.push_back(model(a, s, 1'b0));
    end
  end

  // Single transaction on an idle pipe with out_rdy high; literal expectations.
  task automatic go(input logic [15:0] av, input logic [3:0] sv, input logic [7:0] ez,
                    input logic [7:0] ezt, input bit esat, input int ecnt, input bit doclr);
    a = av; s = sv; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    chk("lat_not_yet", out_vld, 0);
    @(posedge clk); #1;
    chk("lat_two", out_vld, 1);
    chk("z_rnd", z, ez);
    chk("z_trunc", z_t, ezt);
    chk("sat_flag", sat, esat);
    if (doclr) clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("sat_cnt_lit", sat_cnt, ecnt);
  endtask

  task automatic step();
    @(negedge clk);
    acc = in_vld && in_rdy;
    @(posedge clk); #1;
    if (acc) idx++;
    if (idx < 4) begin a = bp_a[idx]; s = bp_s[idx]; in_vld = 1'b1; end
    else in_vld = 1'b0;
  endtask

  initial begin
    #3;
    chk("reset_z", z, 0);
    chk("reset_sat", sat, 0);
    chk("reset_cnt", sat_cnt, 0);
    chk("reset_out_vld", out_vld, 0);
    chk("reset_in_rdy", in_rdy, 0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    #1 chk("rdy_before_edge", in_rdy, 0);
    @(posedge clk); #1;
    chk("rdy_after_edge", in_rdy, 1);

    go(16'h0180, 4'd4, 8'h18, 8'h18, 1'b0, 0, 1'b0);
    go(16'h0018, 4'd4, 8'h02, 8'h01, 1'b0, 0, 1'b0);
    go(16'hFFF8, 4'd4, 8'h00, 8'hFF, 1'b0, 0, 1'b0);
    go(16'h7FFF, 4'd0, 8'h7F, 8'h7F, 1'b1, 1, 1'b0);
    go(16'h8000, 4'd0, 8'h80, 8'h80, 1'b1, 2, 1'b0);
    go(16'h7FFF, 4'd0, 8'h7F, 8'h7F, 1'b1, 0, 1'b1);

    // back-to-back stream, boundary rounding cases
    begin
      int n0;
      n0 = n_out;
      for (int i = 0; i < 6; i++) begin
        a = tp_a[i]; s = tp_s[i]; in_vld = 1'b1;
        @(posedge clk); #1;
      end
      in_vld = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("throughput", n_out - n0, 6);
    end

    // backpressure: out_rdy low for 6 cycles
    out_rdy = 1'b0; idx = 0;
    a = bp_a[0]; s = bp_s[0]; in_vld = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("bp_accepted", idx, 2);
    chk("bp_in_rdy", in_rdy, 0);
    chk("bp_out_vld", out_vld, 1);
    out_rdy = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) step();
    chk("bp_all_accepted", idx, 4);
    in_vld = 1'b0;
    repeat (4) @(posedge clk); #1;

    // reset with both stages full and sat_cnt=5
    clr_cnt = 1'b1; @(posedge clk); #1; clr_cnt = 1'b0;
    a = 16'h7FFF; s = 4'd0; in_vld = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_vld = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("cnt_five", sat_cnt, 5);
    out_rdy = 1'b0;
    a = 16'h8000; s = 4'd0; in_vld = 1'b1;
    @(posedge clk); #1;
    a = 16'h0100;
    @(posedge clk); #1;
    in_vld = 1'b0;
    chk("full_out_vld", out_vld, 1);
    @(negedge clk); #2;
    arst = 1'b1;
    #1;
    chk("arst_out_vld", out_vld, 0);
    chk("arst_cnt", sat_cnt, 0);
    chk("arst_z", z, 0);
    chk("arst_sat", sat, 0);
    chk("arst_in_rdy", in_rdy, 0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0; out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("no_stale", out_vld, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
